cprv_regfile_mp: RTL
====================

// Module: cprv_regfile_mp
// PURPOSE
//  Multi-port integer register file with scoreboard, for the cprv64g pipeline (decode reads, writeback writes).
//  Parametrised read/write port count; x0 hardwired to zero; optional write->read bypass.
//  Post-reset sequencer clears every register, so the array stays reset-free storage.
//  Per-register busy bits track issued-but-unwritten destinations for hazard detection.
// PARAMETERS
//  DATA_WIDTH     64  register width in bits
//  REGADDR_WIDTH  5   address width; depth NREG = 2**REGADDR_WIDTH
//  NUM_RD         2   read ports (>=1)
//  NUM_WR         1   write ports (>=1)
//  BYPASS         1   1: a read returns same-cycle write data; 0: a read returns array contents only
// PORTS
//  clk         in   1                        clock, all state on rising edge
//  rst         in   1                        async active-high reset
//  rs_addr     in   NUM_RD*REGADDR_WIDTH     read addresses, port i at [i*AW +: AW]
//  rs_data     out  NUM_RD*DATA_WIDTH        read data, port i at [i*DW +: DW]
//  rs_busy     out  NUM_RD                   busy bit of the addressed register, per read port
//  wr_en       in   NUM_WR                   write enables
//  wr_addr     in   NUM_WR*REGADDR_WIDTH     write addresses
//  wr_data     in   NUM_WR*DATA_WIDTH        write data
//  rsv_en      in   1                        reserve (mark busy) a destination at issue
//  rsv_addr    in   REGADDR_WIDTH            register to reserve
//  init_done   out  1                        high once the clear sequence has finished
//  wr_unrsv    out  1                        sticky: a write hit a non-busy register (debug)
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=INIT, clear ptr=0, all busy=0, init_done=0, wr_unrsv=0.
//  FSM INIT: one register is written with 0 per cycle, ptr 0..NREG-1. After the ptr=NREG-1 write, FSM goes to RUN.
//   init_done rises on the cycle after the last clear, NREG cycles after reset release.
//  INIT: wr_en and rsv_en are ignored; rs_data=0; rs_busy=0.
//  FSM RUN: stays in RUN until rst. Only reset returns the FSM to INIT.
//  Reset mid-INIT or mid-RUN restarts the clear from ptr 0.
//  Reads: combinational, zero latency. Address 0 always gives data=0 and busy=0.
//  Read, BYPASS=1: if any wr_en[j] targets the same nonzero address, rs_data = wr_data[j].
//   If several ports match, the highest j wins; otherwise rs_data = array value.
//  Read, BYPASS=0: rs_data = array value; the write becomes visible the cycle after the edge.
//  rs_busy reflects registered busy state only; there is no bypass of same-cycle rsv_en or clear.
//  Writes: committed at the rising edge. Writes to address 0 are dropped.
//   Same-address conflict between write ports: the highest-index port wins.
//  Scoreboard: a write commit (wr_en, addr!=0) clears busy[addr]; rsv_en with rsv_addr!=0 sets busy[rsv_addr].
//   Same-cycle reserve and write-clear on one address: reserve wins, busy stays 1 (new producer).
//   Reserving an already-busy register keeps it busy, with no error.
//  wr_unrsv: set when a RUN-state write to addr!=0 finds busy[addr]==0. Held until rst.
//  Width: addresses are unsigned; no data arithmetic; the array has no reset, only the INIT clear.
// TESTING
//  1 Release rst; sample every read at ptr 0..31 -> data 0; init_done rises exactly 32 cycles after release.
//  2 RUN, BYPASS=1: wr x5=0xDEAD_BEEF, same cycle rs_addr0=5 -> rs_data0=0xDEAD_BEEF; next cycle still 0xDEAD_BEEF.
//  3 Write x0=0x1234 with rsv_en on x0 -> reads of x0 return 0 and busy 0, wr_unrsv stays 0.
//  4 rsv x7 -> rs_busy=1 next cycle; wr x7=0x55 plus rsv x7 in one cycle -> busy stays 1, data 0x55.
//  5 NUM_WR=2: both ports write x3 (0x11 on port0, 0x22 on port1) -> x3=0x22; write x9 unreserved -> wr_unrsv=1.
//  6 Assert rst during RUN with x5 holding 0xDEAD_BEEF -> init_done=0 immediately, busy cleared, x5 reads 0 after the re-clear.

Source files
------------

// File: rtl/cprv_regfile_mp.sv
// Multi-port integer register file with busy scoreboard and post-reset clear.
// Ports: rs_* reads, wr_* writes, rsv_* reserve, init_done/wr_unrsv status.
module cprv_regfile_mp #(
  parameter int DATA_WIDTH    = 64,
  parameter int REGADDR_WIDTH = 5,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 1,
  parameter int BYPASS        = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*REGADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rs_data,
  output logic [NUM_RD-1:0]               rs_busy,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR*REGADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
  input  logic                            rsv_en,
  input  logic [REGADDR_WIDTH-1:0]        rsv_addr,
  output logic                            init_done,
  output logic                            wr_unrsv
);

  localparam int AW   = REGADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int NREG = 2 ** AW;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              unrsv_q, unrsv_d;
  logic [DW-1:0]     mem_q [NREG];

  logic [AW-1:0]     wa [NUM_WR];
  logic [DW-1:0]     wd [NUM_WR];
  logic [AW-1:0]     ra [NUM_RD];

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wa[j] = wr_addr[j*AW +: AW];
    assign wd[j] = wr_data[j*DW +: DW];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign ra[i] = rs_addr[i*AW +: AW];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AW'(NREG - 1)) state_d = ST_RUN;
    end
  end

  // Write-clear first, then reserve, so a same-cycle reserve wins.
  always_comb begin
    busy_d  = busy_q;
    unrsv_d = unrsv_q;
    if (state_q == ST_RUN) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wa[j] != '0) begin
          if (!busy_q[wa[j]]) unrsv_d = 1'b1;
          busy_d[wa[j]] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != '0) busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      busy_q  <= '0;
      unrsv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      unrsv_q <= unrsv_d;
    end
  end

  // Reset-free storage; later ports override earlier ones on conflict.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wa[j] != '0) mem_q[wa[j]] <= wd[j];
      end
    end
  end

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (ra[i] != '0) begin
          rs_data[i*DW +: DW] = mem_q[ra[i]];
          rs_busy[i]          = busy_q[ra[i]];
          if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
              if (wr_en[j] && wa[j] == ra[i]) rs_data[i*DW +: DW] = wd[j];
            end
          end
        end
      end
    end
  end

  assign init_done = (state_q == ST_RUN);
  assign wr_unrsv  = unrsv_q;

endmodule
